uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares one UART TX byte stream between NUM_SOURCES AXI-Stream requesters (command responder, log port, debug console, ...).
- Sits directly upstream of the UART TX serializer.
- Holds a grant until the source's packet ends (tlast) or a beat budget expires, so packets are never interleaved on the wire.
- Tags every output beat with the index of the source that produced it.

Parameters:
- NUM_SOURCES, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 8, bits per beat; one UART character.
- MAX_BURST, 16, maximum beats accepted per grant; 0 = unlimited (release only on tlast).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- s_tdata  input  NUM_SOURCES*DATA_WIDTH  source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  input  NUM_SOURCES  per-source valid.
- s_tlast  input  NUM_SOURCES  per-source end of packet.
- s_tready  output  NUM_SOURCES  per-source ready.
- m_tdata  output  DATA_WIDTH  granted data, routed to the UART TX.
- m_tvalid  output  1  output valid.
- m_tlast  output  1  final beat of the current grant.
- m_tid  output  max(1,$clog2(NUM_SOURCES))  index of the granted source.
- m_tready  input  1  UART TX ready.
- busy  output  1  high while in GRANTED.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, grant = 0, last_grant = NUM_SOURCES-1, beat_cnt = 0.
  - s_tready = 0, m_tvalid = 0, m_tlast = 0, m_tid = 0, m_tdata = 0, busy = 0.
- State machine: IDLE, GRANTED.
- IDLE:
  - All s_tready = 0; m_tvalid = 0.
  - If any s_tvalid is high, register grant = first requester searching last_grant+1, last_grant+2, ... modulo NUM_SOURCES.
  - Clear beat_cnt and go to GRANTED.
  - If no s_tvalid is high, stay in IDLE.
- GRANTED (combinational pass-through from the registered grant; no added latency per beat):
  - m_tdata = source[grant] data, m_tvalid = s_tvalid[grant], m_tid = grant.
  - s_tready[grant] = m_tready; all other s_tready = 0.
  - m_tlast = s_tlast[grant] OR (MAX_BURST != 0 AND beat_cnt == MAX_BURST-1).
- Beat acceptance:
  - A beat transfers when m_tvalid && m_tready.
  - On each transfer: beat_cnt increments; it saturates and never wraps.
  - If the transferred beat had m_tlast high: last_grant <= grant and state <= IDLE.
- Latency:
  - The first beat of a grant can transfer no earlier than 1 cycle after the request is seen in IDLE.
  - There is exactly 1 idle turnaround cycle between grants.
- Handshake rules:
  - Once m_tvalid rises, m_tdata, m_tlast and m_tid hold stable until accepted. This follows from the source obeying AXIS, with the grant and beat_cnt frozen while stalled.
  - The grant never changes while in GRANTED unless the last beat transfers.
- The granted source dropping tvalid mid-packet:
  - The grant is held, m_tvalid = 0, and the block waits indefinitely.
  - There is no timeout.
- Budget expiry (beat MAX_BURST accepted without source tlast):
  - m_tlast is asserted on that beat and the grant is released.
  - The source resumes the remainder of its packet on a later grant.
  - The source's own tlast is unaffected.
- Simultaneous events:
  - New requests arriving during GRANTED are only sampled in IDLE.
  - A request from the just-released source competes at lowest priority.
- Single requester: it is re-granted every other cycle; each grant is separated by one idle cycle.
- Reset mid-packet:
  - The grant is dropped immediately and s_tready is 0 in the reset cycle.
  - The next grant starts from source 0.
  - The partial packet is not completed by this block.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits, minimum 1.
  - The round-robin search is purely combinational over NUM_SOURCES.

Test Plan:
- Reset, then sources 0 and 2 each send a 3-byte packet (0x41 0x42 0x43 and 0x61 0x62 0x63), with m_tready held 1 -> required output: 0x41,0x42,0x43 with m_tid=0, m_tlast on 0x43; 1 idle cycle; then 0x61,0x62,0x63 with m_tid=2, m_tlast on 0x63.
- All 4 sources continuously request single-byte packets -> m_tid sequence 0,1,2,3,0,1,... with one idle cycle between grants.
- MAX_BURST=4, source 1 sends a 6-byte packet while source 3 is requesting -> output: 4 beats with m_tid=1 and m_tlast on the 4th; then source 3's packet; then the remaining 2 beats from source 1 with its own tlast.
- m_tready toggled 1,0,0,1 during a packet -> m_tdata, m_tlast and m_tid stay stable through the stall; no byte is lost or duplicated; the non-granted s_tready stays 0 throughout.
- reset asserted on the 2nd beat of a packet from source 2 -> s_tready is 0 in that cycle and busy=0 the next cycle; a subsequent request from sources 2 and 0 grants source 0 first.
- The granted source drops tvalid for 10 cycles mid-packet while source 1 requests -> the grant is held, m_tvalid=0, and source 1 is not served until the granted packet ends.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-aware round-robin arbiter that merges several
//               AXI-Stream byte sources into one UART TX stream.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 16
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]                      s_tdata,
    input  logic [NUM_SOURCES-1:0]                                 s_tvalid,
    input  logic [NUM_SOURCES-1:0]                                 s_tlast,
    output logic [NUM_SOURCES-1:0]                                 s_tready,
    output logic [DATA_WIDTH-1:0]                                  m_tdata,
    output logic                                                   m_tvalid,
    output logic                                                   m_tlast,
    output logic [((NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1)-1:0] m_tid,
    input  logic                                                   m_tready,
    output logic                                                   busy
);

    localparam int c_tid_w = (NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1;
    localparam int c_cnt_w = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max    = '1;
    localparam logic [c_cnt_w-1:0] c_burst_last = c_cnt_w'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
    localparam logic               c_budget_en  = (MAX_BURST > 0);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_tid_w-1:0]   r_grant;
    logic [c_tid_w-1:0]   r_last_grant;
    logic [c_cnt_w-1:0]   r_beat_cnt;
    logic [c_tid_w-1:0]   w_rr_pick;
    logic [c_tid_w-1:0]   w_idx;
    logic                 w_rr_found;
    logic                 w_active;
    logic                 w_xfer;
    logic [DATA_WIDTH-1:0] w_src_data;

    // Search starts one past the last served source, so it ranks lowest.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = '0;
        w_idx      = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            w_idx = c_tid_w'((int'(r_last_grant) + k) % NUM_SOURCES);
            if (!w_rr_found && s_tvalid[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_idx;
            end
        end
    end

    assign w_src_data = s_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];

    // Reset gates the pass-through so no handshake completes in the reset cycle.
    assign w_active = (r_state == ST_GRANTED) && !reset;
    assign busy     = w_active;
    assign w_xfer   = m_tvalid && m_tready;

    always_comb begin
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tid    = '0;
        if (w_active) begin
            m_tdata           = w_src_data;
            m_tvalid          = s_tvalid[r_grant];
            m_tlast           = s_tlast[r_grant] || (c_budget_en && (r_beat_cnt == c_burst_last));
            m_tid             = r_grant;
            s_tready[r_grant] = m_tready;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found) begin
                    w_state_nxt = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (w_xfer && m_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_last_grant <= c_tid_w'(NUM_SOURCES - 1);
            r_beat_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_rr_found) begin
                r_grant    <= w_rr_pick;
                r_beat_cnt <= '0;
            end
        end else if (w_xfer) begin
            if (r_beat_cnt != c_cnt_max) begin
                r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            end
            if (m_tlast) begin
                r_last_grant <= r_grant;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter (4 sources,
//               8-bit beats, 4-beat budget).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NS*DW-1:0]  s_tdata;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tlast;
    logic [NS-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic [1:0]        m_tid;
    logic              m_tready;
    logic              busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_SOURCES (NS),
        .DATA_WIDTH  (DW),
        .MAX_BURST   (MB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_tready (m_tready),
        .busy     (busy)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0;

    // Per-source beat queues replayed onto the AXIS inputs.
    logic [7:0] src_data [NS][16];
    logic       src_lst  [NS][16];
    int         src_len  [NS];
    int         src_ptr  [NS];
    logic       hold     [NS];
    logic       hs       [NS];

    logic [7:0] out_data [64];
    logic [1:0] out_tid  [64];
    logic       out_last [64];
    int         out_cyc  [64];
    int         out_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string t, input int k, input logic [1:0] tid,
                            input logic [7:0] d, input logic l);
        chk($sformatf("%s_tid%0d", t, k), 32'(out_tid[k]), 32'(tid));
        chk($sformatf("%s_data%0d", t, k), 32'(out_data[k]), 32'(d));
        chk($sformatf("%s_last%0d", t, k), 32'(out_last[k]), 32'(l));
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        src_data[s][src_len[s]] = d;
        src_lst[s][src_len[s]]  = l;
        src_len[s]++;
    endtask

    task automatic clear_src(input int s);
        src_len[s] = 0;
        src_ptr[s] = 0;
        hold[s]    = 1'b0;
    endtask

    task automatic clear_log();
        out_n = 0;
        for (int k = 0; k < 64; k++) begin
            out_data[k] = 'x;
            out_tid[k]  = 'x;
            out_last[k] = 'x;
            out_cyc[k]  = -1;
        end
    endtask

    // Drive inputs, then sample outputs on the falling edge.
    task automatic half();
        for (int i = 0; i < NS; i++) begin
            if (src_ptr[i] < src_len[i] && !hold[i]) begin
                s_tvalid[i]        = 1'b1;
                s_tdata[i*DW +: DW] = src_data[i][src_ptr[i]];
                s_tlast[i]         = src_lst[i][src_ptr[i]];
            end else begin
                s_tvalid[i]        = 1'b0;
                s_tdata[i*DW +: DW] = '0;
                s_tlast[i]         = 1'b0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            hs[i] = s_tvalid[i] & s_tready[i];
        end
        if (m_tvalid && m_tready && out_n < 64) begin
            out_data[out_n] = m_tdata;
            out_tid[out_n]  = m_tid;
            out_last[out_n] = m_tlast;
            out_cyc[out_n]  = cyc;
            out_n++;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                src_ptr[i]++;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            half();
            adv();
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            clear_src(i);
        end
        cycles(2);
        reset = 1'b0;
        clear_log();
    endtask

    initial begin
        reset    = 1'b1;
        m_tready = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < NS; i++) begin
            clear_src(i);
            hs[i] = 1'b0;
        end
        clear_log();
        @(posedge clk);
        #1;

        // Reset state
        half();
        chk("rst_tready", 32'(s_tready), 32'h0);
        chk("rst_mvalid", 32'(m_tvalid), 32'h0);
        chk("rst_busy",   32'(busy),     32'h0);
        adv();
        cycles(1);
        reset = 1'b0;
        half();
        chk("idle_busy",  32'(busy),    32'h0);
        chk("idle_tid",   32'(m_tid),   32'h0);
        chk("idle_tdata", 32'(m_tdata), 32'h0);
        chk("idle_tlast", 32'(m_tlast), 32'h0);
        adv();

        // Two 3-byte packets from sources 0 and 2
        clear_log();
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b1);
        t0 = cyc;
        cycles(12);
        chk("t1_count", 32'(out_n), 32'd6);
        chk_beat("t1", 0, 2'd0, 8'h41, 1'b0);
        chk_beat("t1", 1, 2'd0, 8'h42, 1'b0);
        chk_beat("t1", 2, 2'd0, 8'h43, 1'b1);
        chk_beat("t1", 3, 2'd2, 8'h61, 1'b0);
        chk_beat("t1", 4, 2'd2, 8'h62, 1'b0);
        chk_beat("t1", 5, 2'd2, 8'h63, 1'b1);
        chk("t1_first_lat", 32'(out_cyc[0] - t0), 32'd1);
        chk("t1_gap",       32'(out_cyc[3] - out_cyc[2]), 32'd2);
        chk("t1_back2back", 32'(out_cyc[5] - out_cyc[3]), 32'd2);

        // All four sources with single-byte packets
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < NS; s++) begin
                push(s, 8'(8'h80 + s * 2 + p), 1'b1);
            end
        end
        t0 = cyc;
        cycles(20);
        chk("t2_count", 32'(out_n), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_tid%0d", k), 32'(out_tid[k]), 32'(k % 4));
            chk($sformatf("t2_cyc%0d", k), 32'(out_cyc[k] - t0), 32'(2 * k + 1));
        end

        // Budget expiry: 6-byte packet on source 1 vs 2-byte packet on source 3
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push(1, 8'(8'h10 + k), (k == 5));
        end
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
        cycles(20);
        chk("t3_count", 32'(out_n), 32'd8);
        chk_beat("t3", 0, 2'd1, 8'h10, 1'b0);
        chk_beat("t3", 1, 2'd1, 8'h11, 1'b0);
        chk_beat("t3", 2, 2'd1, 8'h12, 1'b0);
        chk_beat("t3", 3, 2'd1, 8'h13, 1'b1);
        chk_beat("t3", 4, 2'd3, 8'h30, 1'b0);
        chk_beat("t3", 5, 2'd3, 8'h31, 1'b1);
        chk_beat("t3", 6, 2'd1, 8'h14, 1'b0);
        chk_beat("t3", 7, 2'd1, 8'h15, 1'b1);

        // Backpressure stall on the last beat of a packet
        do_reset();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b1);
        cycles(1);
        half();
        chk("t4_rdy_go", 32'(s_tready), 32'h1);
        adv();
        m_tready = 1'b0;
        repeat (2) begin
            half();
            chk("t4_stall_valid", 32'(m_tvalid), 32'h1);
            chk("t4_stall_data",  32'(m_tdata),  32'hA1);
            chk("t4_stall_last",  32'(m_tlast),  32'h1);
            chk("t4_stall_tid",   32'(m_tid),    32'h0);
            chk("t4_stall_rdy",   32'(s_tready), 32'h0);
            adv();
        end
        m_tready = 1'b1;
        cycles(6);
        chk("t4_count", 32'(out_n), 32'd3);
        chk_beat("t4", 0, 2'd0, 8'hA0, 1'b0);
        chk_beat("t4", 1, 2'd0, 8'hA1, 1'b1);
        chk_beat("t4", 2, 2'd1, 8'hB0, 1'b1);

        // Reset on the second beat of a packet from source 2
        do_reset();
        push(2, 8'hE0, 1'b0); push(2, 8'hE1, 1'b0); push(2, 8'hE2, 1'b1);
        cycles(2);
        reset = 1'b1;
        half();
        chk("t5_rst_rdy",   32'(s_tready), 32'h0);
        chk("t5_rst_valid", 32'(m_tvalid), 32'h0);
        adv();
        reset = 1'b0;
        clear_src(2);
        half();
        chk("t5_busy_after", 32'(busy), 32'h0);
        adv();
        clear_log();
        push(2, 8'hE5, 1'b1);
        push(0, 8'h05, 1'b1);
        cycles(8);
        chk("t5_count", 32'(out_n), 32'd2);
        chk_beat("t5", 0, 2'd0, 8'h05, 1'b1);
        chk_beat("t5", 1, 2'd2, 8'hE5, 1'b1);

        // Granted source goes quiet mid-packet while source 1 waits
        do_reset();
        push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b1);
        push(1, 8'hD0, 1'b1);
        cycles(2);
        hold[0] = 1'b1;
        repeat (10) begin
            half();
            chk("t6_hold_valid", 32'(m_tvalid),    32'h0);
            chk("t6_hold_busy",  32'(busy),        32'h1);
            chk("t6_hold_tid",   32'(m_tid),       32'h0);
            chk("t6_hold_rdy1",  32'(s_tready[1]), 32'h0);
            adv();
        end
        hold[0] = 1'b0;
        cycles(10);
        chk("t6_count", 32'(out_n), 32'd4);
        chk_beat("t6", 0, 2'd0, 8'hC0, 1'b0);
        chk_beat("t6", 1, 2'd0, 8'hC1, 1'b0);
        chk_beat("t6", 2, 2'd0, 8'hC2, 1'b1);
        chk_beat("t6", 3, 2'd1, 8'hD0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
